uart_rx_param: RTL and testbench

Parametrised UART receiver and the next generation of uart_rx_top.
- Runtime-selectable data length (5..MAX_DATA_W), parity on/off and type, 1 or 2 stop bits.
- Wider prescale, 3-sample majority vote per bit, input synchroniser, break detection.
- Sits between the RX pin and the byte consumer and feeds the same P_DATA / DATA_VLD / error-flag interface.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sampler.sv | 62 ++++++
 rtl/uart_rx_param.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_ODD      = 1'b1;
  localparam int   MIN_PRESCALE = 4;
  localparam int   MIN_DATA_LEN = 5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX input synchroniser, falling-edge detect, per-bit edge counter and
// 3-sample majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  active,
  input  logic                  hold,
  input  logic                  start,
  input  logic [PRESCALE_W-1:0] ps,
  output logic                  rx_fall,
  output logic                  bit_val,
  output logic                  bit_strobe,
  output logic                  bit_end
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  logic                   s0;
  logic                   s1;
  logic [PRESCALE_W-1:0]  edge_cnt;
  logic [PRESCALE_W-1:0]  half;
  logic [PRESCALE_W-1:0]  last;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign half       = ps >> 1;
  assign last       = ps - PRESCALE_W'(1);
  assign rx_fall    = rx_prev && !rx_s;
  assign bit_strobe = active && (edge_cnt == half + PRESCALE_W'(1));
  // While held after a break, bit_end marks one full bit time of idle-high line.
  assign bit_end    = (edge_cnt == last) && (active || (hold && rx_s));
  assign bit_val    = maj3(s0, s1, rx_s);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q   <= '1;
      rx_prev  <= 1'b1;
      edge_cnt <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], RX_IN};
      rx_prev <= rx_s;
      // The edge cycle itself is count 0, so the first START cycle is count 1.
      if (active)
        edge_cnt <= bit_end ? '0 : edge_cnt + PRESCALE_W'(1);
      else if (hold)
        edge_cnt <= (rx_s && !bit_end) ? edge_cnt + PRESCALE_W'(1) : '0;
      else
        edge_cnt <= start ? PRESCALE_W'(1) : '0;
      if (active && (edge_cnt == half - PRESCALE_W'(1))) s0 <= rx_s;
      if (active && (edge_cnt == half)) s1 <= rx_s;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, shift register, parity/stop checks,
// break detection and word commit on top of uart_rx_sampler.
//
//   state  | meaning
//   IDLE   | waiting for start edge (or for one idle bit time after a break)
//   START  | start bit, false start if its majority is 1
//   DATA   | shifting DATA_LEN bits LSB-first
//   PARITY | parity bit check
//   STOP1  | first stop bit, break decision
//   STOP2  | optional second stop bit
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int MAX_DATA_W  = 9,
  parameter int PRESCALE_W  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STP2,
  input  logic [3:0]            DATA_LEN,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [MAX_DATA_W-1:0] P_DATA,
  output logic                  DATA_VLD,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  STR_ERR,
  output logic                  BRK_DET
);

  localparam logic [3:0] LEN_MIN = 4'(MIN_DATA_LEN);
  localparam logic [3:0] LEN_MAX = 4'(MAX_DATA_W);

  state_t                state, state_nx;
  logic                  par_en_q, par_typ_q, stp2_q;
  logic [3:0]            len_q, len_clamped, bit_idx, bits_done;
  logic [PRESCALE_W-1:0] ps_q;
  logic [MAX_DATA_W-1:0] shreg;
  logic                  armed, par_bad, par_bit, stp_bad, brk_seen;
  logic                  rx_fall, bit_val, bit_strobe, bit_end;
  logic                  start, frame_end, commit, brk_now;
  logic                  par_err_nx, stp_err_nx, str_err_nx, brk_nx;

  assign len_clamped = (DATA_LEN < LEN_MIN) ? LEN_MIN :
                       (DATA_LEN > LEN_MAX) ? LEN_MAX : DATA_LEN;
  assign start       = (state == IDLE) && armed && rx_fall &&
                       (prescale >= PRESCALE_W'(MIN_PRESCALE));
  // At small prescales the last strobe and the bit end share a cycle.
  assign bits_done   = bit_strobe ? bit_idx + 4'd1 : bit_idx;
  assign brk_now     = (shreg == '0) && (!par_en_q || !par_bit) && !bit_val;
  assign commit      = frame_end && !par_bad && !stp_bad && !stp_err_nx;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .active    (state != IDLE),
    .hold      ((state == IDLE) && !armed),
    .start     (start),
    .ps        (ps_q),
    .rx_fall   (rx_fall),
    .bit_val   (bit_val),
    .bit_strobe(bit_strobe),
    .bit_end   (bit_end)
  );

  always_comb begin
    state_nx   = state;
    par_err_nx = 1'b0;
    stp_err_nx = 1'b0;
    str_err_nx = 1'b0;
    brk_nx     = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: if (start) state_nx = START;
      START: begin
        if (bit_strobe && bit_val) begin
          str_err_nx = 1'b1;
          state_nx   = IDLE;
        end else if (bit_end) begin
          state_nx = DATA;
        end
      end
      DATA: if (bit_end && (bits_done == len_q)) state_nx = par_en_q ? PARITY : STOP1;
      PARITY: begin
        if (bit_strobe) par_err_nx = bit_val != ((^shreg) ^ (par_typ_q == PAR_ODD));
        if (bit_end) state_nx = STOP1;
      end
      STOP1: begin
        if (bit_strobe) begin
          stp_err_nx = !bit_val;
          brk_nx     = brk_now;
          if (!stp2_q) begin
            state_nx  = IDLE;
            frame_end = 1'b1;
          end
        end
        if (stp2_q && bit_end) state_nx = STOP2;
      end
      STOP2: begin
        if (bit_strobe) begin
          stp_err_nx = !bit_val && !stp_bad;
          state_nx   = IDLE;
          frame_end  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      stp2_q    <= 1'b0;
      len_q     <= '0;
      ps_q      <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      armed     <= 1'b1;
      par_bad   <= 1'b0;
      par_bit   <= 1'b0;
      stp_bad   <= 1'b0;
      brk_seen  <= 1'b0;
      P_DATA    <= '0;
      DATA_VLD  <= 1'b0;
      PAR_ERR   <= 1'b0;
      STP_ERR   <= 1'b0;
      STR_ERR   <= 1'b0;
      BRK_DET   <= 1'b0;
    end else begin
      state    <= state_nx;
      DATA_VLD <= commit;
      PAR_ERR  <= par_err_nx;
      STP_ERR  <= stp_err_nx;
      STR_ERR  <= str_err_nx;
      BRK_DET  <= brk_nx;
      if (commit) P_DATA <= shreg;
      if (start) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        stp2_q    <= STP2;
        len_q     <= len_clamped;
        ps_q      <= prescale;
        shreg     <= '0;
        bit_idx   <= '0;
        par_bad   <= 1'b0;
        par_bit   <= 1'b0;
        stp_bad   <= 1'b0;
        brk_seen  <= 1'b0;
      end
      if ((state == DATA) && bit_strobe) begin
        shreg[bit_idx] <= bit_val;
        bit_idx        <= bit_idx + 4'd1;
      end
      if ((state == PARITY) && bit_strobe) par_bit <= bit_val;
      if (par_err_nx) par_bad <= 1'b1;
      if (stp_err_nx) stp_bad <= 1'b1;
      if (brk_nx) brk_seen <= 1'b1;
      // After a break the line must idle high for a full bit before re-arming.
      if (frame_end && (brk_seen || brk_nx)) armed <= 1'b0;
      else if ((state == IDLE) && !armed && bit_end) armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_uart_rx_param;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STP2;
  logic [3:0] DATA_LEN;
  logic [7:0] prescale;
  logic [8:0] P_DATA;
  logic       DATA_VLD, PAR_ERR, STP_ERR, STR_ERR, BRK_DET;

  uart_rx_param #(.MAX_DATA_W(9), .PRESCALE_W(8), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STP2(STP2), .DATA_LEN(DATA_LEN), .prescale(prescale), .P_DATA(P_DATA),
    .DATA_VLD(DATA_VLD), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
    .STR_ERR(STR_ERR), .BRK_DET(BRK_DET)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  // Pulse monitor: counts high cycles of each output and logs committed words.
  int n_vld = 0, n_par = 0, n_stp = 0, n_str = 0, n_brk = 0, n_bs = 0;
  logic [8:0] vld_log [0:255];

  always @(negedge CLK) begin
    if (DATA_VLD) begin
      vld_log[n_vld[7:0]] <= P_DATA;
      n_vld <= n_vld + 1;
    end
    if (PAR_ERR) n_par <= n_par + 1;
    if (STP_ERR) n_stp <= n_stp + 1;
    if (STR_ERR) n_str <= n_str + 1;
    if (BRK_DET) n_brk <= n_brk + 1;
    if (BRK_DET && STP_ERR) n_bs <= n_bs + 1;
  end

  typedef struct { int vld, par, stp, str, brk, bs; } cnt_t;
  typedef struct { logic vld, perr, serr, brk; logic [8:0] word; } exp_t;

  function automatic cnt_t snap();
    cnt_t c;
    c.vld = n_vld; c.par = n_par; c.stp = n_stp;
    c.str = n_str; c.brk = n_brk; c.bs = n_bs;
    return c;
  endfunction

  function automatic cnt_t delta(input cnt_t b);
    cnt_t c;
    c.vld = n_vld - b.vld; c.par = n_par - b.par; c.stp = n_stp - b.stp;
    c.str = n_str - b.str; c.brk = n_brk - b.brk; c.bs = n_bs - b.bs;
    return c;
  endfunction

  function automatic int clamp_len(input int l);
    if (l < 5) return 5;
    if (l > 9) return 9;
    return l;
  endfunction

  // Parity bit that makes the ones count even (ptyp=0) or odd (ptyp=1).
  function automatic logic good_par(input logic [8:0] w, input logic ptyp);
    return 1'(($countones(w) + int'(ptyp)) % 2);
  endfunction

  function automatic exp_t model(input logic [8:0] word, input logic pen, input logic ptyp,
                                 input logic st2, input logic pbit, input logic s1,
                                 input logic s2);
    exp_t m;
    m.perr = pen && ((($countones(word) + int'(pbit)) % 2) != int'(ptyp));
    m.serr = !s1 || (st2 && !s2);
    m.brk  = (word == 9'd0) && (!pen || !pbit) && !s1;
    m.vld  = !m.perr && !m.serr;
    m.word = word;
    return m;
  endfunction

  task automatic set_cfg(input int ps, input int len_raw, input logic pen,
                         input logic ptyp, input logic st2);
    prescale = 8'(ps);
    DATA_LEN = 4'(len_raw);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    STP2     = st2;
  endtask

  task automatic send_frame(input logic [8:0] data, input int len, input logic pen,
                            input logic pbit, input logic st2, input int ps,
                            input logic s1, input logic s2, input int glitch_bit,
                            input int idle);
    RX_IN = 1'b0;
    repeat (ps) @(negedge CLK);
    for (int i = 0; i < len; i++) begin
      RX_IN = data[i];
      if (i == glitch_bit) begin
        repeat (ps / 2) @(negedge CLK);
        RX_IN = ~data[i];
        @(negedge CLK);
        RX_IN = data[i];
        repeat (ps - ps / 2 - 1) @(negedge CLK);
      end else begin
        repeat (ps) @(negedge CLK);
      end
    end
    if (pen) begin
      RX_IN = pbit;
      repeat (ps) @(negedge CLK);
    end
    RX_IN = s1;
    repeat (ps) @(negedge CLK);
    if (st2) begin
      RX_IN = s2;
      repeat (ps) @(negedge CLK);
    end
    RX_IN = 1'b1;
    repeat (idle) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_IN = 1'b1;
    set_cfg(8, 8, 0, 0, 0);
    repeat (3) @(negedge CLK);
    checks++;
    if (P_DATA !== 9'h000) $display("FAIL reset_pdata: got %h want 000", P_DATA);
    else passed++;
    checks++;
    if ({DATA_VLD, PAR_ERR, STP_ERR, STR_ERR, BRK_DET} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {DATA_VLD, PAR_ERR, STP_ERR, STR_ERR, BRK_DET});
    else passed++;
    RST = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_basic();
    cnt_t b, d;
    set_cfg(8, 8, 1, 0, 0);
    b = snap();
    send_frame(9'h0AD, 8, 1, good_par(9'h0AD, 0), 0, 8, 1, 1, -1, 24);
    d = delta(b);
    checks++;
    if (d.vld !== 1) $display("FAIL basic_vld: got %0d pulses want 1", d.vld); else passed++;
    checks++;
    if (P_DATA !== 9'h0AD) $display("FAIL basic_pdata: got %h want 0ad", P_DATA); else passed++;
    checks++;
    if (d.par + d.stp + d.str + d.brk !== 0)
      $display("FAIL basic_errs: got %0d error pulses want 0", d.par + d.stp + d.str + d.brk);
    else passed++;
  endtask

  task automatic test_back_to_back();
    cnt_t b, d;
    int idx;
    set_cfg(16, 5, 0, 0, 1);
    b = snap();
    idx = b.vld % 256;
    send_frame(9'h015, 5, 0, 0, 1, 16, 1, 1, -1, 0);
    send_frame(9'h00A, 5, 0, 0, 1, 16, 1, 1, -1, 40);
    d = delta(b);
    checks++;
    if (d.vld !== 2) $display("FAIL b2b_vld: got %0d pulses want 2", d.vld); else passed++;
    checks++;
    if (vld_log[idx] !== 9'h015) $display("FAIL b2b_first: got %h want 015", vld_log[idx]);
    else passed++;
    checks++;
    if (vld_log[(idx + 1) % 256] !== 9'h00A)
      $display("FAIL b2b_second: got %h want 00a", vld_log[(idx + 1) % 256]);
    else passed++;
    checks++;
    if (d.par + d.stp + d.str + d.brk !== 0)
      $display("FAIL b2b_errs: got %0d error pulses want 0", d.par + d.stp + d.str + d.brk);
    else passed++;
  endtask

  task automatic test_start_err();
    cnt_t b, d;
    set_cfg(32, 8, 0, 0, 0);
    b = snap();
    RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (64) @(negedge CLK);
    d = delta(b);
    checks++;
    if (d.str !== 1) $display("FAIL str_pulse: got %0d want 1", d.str); else passed++;
    checks++;
    if (d.vld !== 0) $display("FAIL str_novld: got %0d want 0", d.vld); else passed++;
    b = snap();
    send_frame(9'h075, 8, 0, 0, 0, 32, 1, 1, -1, 80);
    d = delta(b);
    checks++;
    if (d.vld !== 1) $display("FAIL str_next_vld: got %0d want 1", d.vld); else passed++;
    checks++;
    if (P_DATA !== 9'h075) $display("FAIL str_next_pdata: got %h want 075", P_DATA); else passed++;
  endtask

  task automatic test_parity_err();
    cnt_t b, d;
    set_cfg(8, 8, 1, 1, 0);
    b = snap();
    send_frame(9'h05C, 8, 1, ~good_par(9'h05C, 1), 0, 8, 1, 1, -1, 24);
    d = delta(b);
    checks++;
    if (d.par !== 1) $display("FAIL par_pulse: got %0d want 1", d.par); else passed++;
    checks++;
    if (d.vld !== 0 || d.stp !== 0)
      $display("FAIL par_side: got vld %0d stp %0d want 0 0", d.vld, d.stp);
    else passed++;
    checks++;
    if (P_DATA !== 9'h075) $display("FAIL par_keep: got %h want 075", P_DATA); else passed++;
  endtask

  task automatic test_stop_break();
    cnt_t b, d;
    set_cfg(16, 8, 0, 0, 1);
    b = snap();
    send_frame(9'h03C, 8, 0, 0, 1, 16, 1, 0, -1, 48);
    d = delta(b);
    checks++;
    if (d.stp !== 1 || d.brk !== 0 || d.vld !== 0)
      $display("FAIL stop2_err: got stp %0d brk %0d vld %0d want 1 0 0", d.stp, d.brk, d.vld);
    else passed++;
    b = snap();
    send_frame(9'h000, 8, 0, 0, 1, 16, 0, 0, -1, 0);
    RX_IN = 1'b0;
    repeat (32) @(negedge CLK);
    d = delta(b);
    checks++;
    if (d.stp !== 1) $display("FAIL brk_stp: got %0d want 1", d.stp); else passed++;
    checks++;
    if (d.brk !== 1) $display("FAIL brk_pulse: got %0d want 1", d.brk); else passed++;
    checks++;
    if (d.bs !== 1) $display("FAIL brk_same_cycle: got %0d want 1", d.bs); else passed++;
    checks++;
    if (d.vld !== 0) $display("FAIL brk_novld: got %0d want 0", d.vld); else passed++;
    // Line high for less than a bit, then low again: must not re-arm yet.
    b = snap();
    RX_IN = 1'b1;
    repeat (13) @(negedge CLK);
    RX_IN = 1'b0;
    repeat (48) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (192) @(negedge CLK);
    d = delta(b);
    checks++;
    if (d.vld + d.stp + d.str !== 0)
      $display("FAIL brk_hold: got vld %0d stp %0d str %0d want 0 0 0", d.vld, d.stp, d.str);
    else passed++;
    b = snap();
    send_frame(9'h096, 8, 0, 0, 1, 16, 1, 1, -1, 48);
    d = delta(b);
    checks++;
    if (d.vld !== 1 || P_DATA !== 9'h096)
      $display("FAIL brk_rearm: got vld %0d data %h want 1 096", d.vld, P_DATA);
    else passed++;
  endtask

  task automatic test_glitch();
    cnt_t b, d;
    set_cfg(16, 8, 0, 0, 0);
    b = snap();
    send_frame(9'h0D1, 8, 0, 0, 0, 16, 1, 1, 3, 40);
    d = delta(b);
    checks++;
    if (d.vld !== 1) $display("FAIL glitch_vld: got %0d want 1", d.vld); else passed++;
    checks++;
    if (P_DATA !== 9'h0D1) $display("FAIL glitch_pdata: got %h want 0d1", P_DATA); else passed++;
  endtask

  task automatic test_bad_prescale();
    cnt_t b, d;
    set_cfg(3, 8, 0, 0, 0);
    b = snap();
    send_frame(9'h000, 8, 0, 0, 0, 3, 1, 1, -1, 30);
    d = delta(b);
    checks++;
    if (d.vld + d.par + d.stp + d.str + d.brk !== 0)
      $display("FAIL low_prescale: got %0d pulses want 0", d.vld + d.par + d.stp + d.str + d.brk);
    else passed++;
  endtask

  task automatic test_reset_mid();
    cnt_t b, d;
    set_cfg(16, 8, 0, 0, 0);
    RX_IN = 1'b0;
    repeat (16) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (40) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({P_DATA, DATA_VLD, PAR_ERR, STP_ERR, STR_ERR, BRK_DET} !== 14'd0)
      $display("FAIL midrst_outputs: got data %h flags %b want 000 00000", P_DATA,
               {DATA_VLD, PAR_ERR, STP_ERR, STR_ERR, BRK_DET});
    else passed++;
    RST = 1'b0;
    b = snap();
    repeat (320) @(negedge CLK);
    d = delta(b);
    checks++;
    if (d.vld + d.par + d.stp + d.str + d.brk !== 0)
      $display("FAIL midrst_quiet: got %0d pulses want 0", d.vld + d.par + d.stp + d.str + d.brk);
    else passed++;
  endtask

  task automatic test_random();
    cnt_t b, d;
    exp_t e;
    logic [8:0] exp_pd, word;
    logic pen, ptyp, st2, pbit, s1, s2;
    int ps, lraw, len;
    exp_pd = 9'h000;
    for (int n = 0; n < 12; n++) begin
      ps   = $urandom_range(4, 20);
      lraw = $urandom_range(2, 13);
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      st2  = 1'($urandom_range(0, 1));
      len  = clamp_len(lraw);
      word = 9'($urandom) & 9'((1 << len) - 1);
      pbit = good_par(word, ptyp) ^ ($urandom_range(0, 3) == 0);
      s1   = ($urandom_range(0, 5) != 0);
      s2   = ($urandom_range(0, 5) != 0);
      e    = model(word, pen, ptyp, st2, pbit, s1, s2);
      if (e.vld) exp_pd = e.word;
      set_cfg(ps, lraw, pen, ptyp, st2);
      b = snap();
      send_frame(word, len, pen, pbit, st2, ps, s1, s2, -1, 2 * ps + 8);
      d = delta(b);
      checks++;
      if (d.vld !== int'(e.vld)) $display("FAIL rnd%0d_vld: got %0d want %0d", n, d.vld, e.vld);
      else passed++;
      checks++;
      if (d.par !== int'(e.perr)) $display("FAIL rnd%0d_par: got %0d want %0d", n, d.par, e.perr);
      else passed++;
      checks++;
      if (d.stp !== int'(e.serr)) $display("FAIL rnd%0d_stp: got %0d want %0d", n, d.stp, e.serr);
      else passed++;
      checks++;
      if (d.brk !== int'(e.brk)) $display("FAIL rnd%0d_brk: got %0d want %0d", n, d.brk, e.brk);
      else passed++;
      checks++;
      if (d.str !== 0) $display("FAIL rnd%0d_str: got %0d want 0", n, d.str);
      else passed++;
      checks++;
      if (P_DATA !== exp_pd) $display("FAIL rnd%0d_pdata: got %h want %h", n, P_DATA, exp_pd);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_err();
    test_parity_err();
    test_stop_break();
    test_glitch();
    test_bad_prescale();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
